// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: selects the ALU or multiplier result, registers it with
// the memory/writeback controls, and exposes a forwarding port and a MUL retire counter.
module ex_mem_pipe_reg #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  ex_is_mul_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       mul_result_i,
    input  logic [XLEN-1:0]       store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_write_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  mem_valid_o,
    output logic [XLEN-1:0]       mem_result_o,
    output logic [XLEN-1:0]       mem_store_data_o,
    output logic [REG_ADDR_W-1:0] mem_rd_addr_o,
    output logic                  mem_reg_write_o,
    output logic                  mem_mem_read_o,
    output logic                  mem_mem_write_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_addr_o,
    output logic [XLEN-1:0]       fwd_data_o,
    output logic [CNT_W-1:0]      mul_count_o
);

    logic                  load;
    logic                  valid_n;
    logic [XLEN-1:0]       result_n;
    logic [XLEN-1:0]       store_data_n;
    logic [REG_ADDR_W-1:0] rd_addr_n;
    logic                  reg_write_n;
    logic                  mem_read_n;
    logic                  mem_write_n;
    logic [2:0]            funct3_n;
    logic                  fwd_valid_n;
    logic [CNT_W-1:0]      mul_count_n;

    assign load = ~flush_i & ~stall_i;

    // Next-state: hold by default, bubble on flush, load from EX otherwise
    always_comb begin
        valid_n      = mem_valid_o;
        result_n     = mem_result_o;
        store_data_n = mem_store_data_o;
        rd_addr_n    = mem_rd_addr_o;
        reg_write_n  = mem_reg_write_o;
        mem_read_n   = mem_mem_read_o;
        mem_write_n  = mem_mem_write_o;
        funct3_n     = mem_funct3_o;
        mul_count_n  = mul_count_o;

        if (flush_i) begin
            valid_n     = 1'b0;
            reg_write_n = 1'b0;
            mem_read_n  = 1'b0;
            mem_write_n = 1'b0;
        end else if (load) begin
            valid_n      = ex_valid_i;
            result_n     = (ex_valid_i & ex_is_mul_i) ? mul_result_i : alu_result_i;
            store_data_n = store_data_i;
            rd_addr_n    = rd_addr_i;
            reg_write_n  = ex_valid_i & reg_write_i & (rd_addr_i != '0);
            mem_read_n   = ex_valid_i & mem_read_i;
            mem_write_n  = ex_valid_i & mem_write_i;
            funct3_n     = funct3_i;
            if (ex_valid_i & ex_is_mul_i) begin
                mul_count_n = mul_count_o + CNT_W'(1);
            end
        end

        // Load data only exists after MEM, so loads never forward from here
        fwd_valid_n = valid_n & reg_write_n & ~mem_read_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_o      <= 1'b0;
            mem_result_o     <= '0;
            mem_store_data_o <= '0;
            mem_rd_addr_o    <= '0;
            mem_reg_write_o  <= 1'b0;
            mem_mem_read_o   <= 1'b0;
            mem_mem_write_o  <= 1'b0;
            mem_funct3_o     <= '0;
            fwd_valid_o      <= 1'b0;
            mul_count_o      <= '0;
        end else begin
            mem_valid_o      <= valid_n;
            mem_result_o     <= result_n;
            mem_store_data_o <= store_data_n;
            mem_rd_addr_o    <= rd_addr_n;
            mem_reg_write_o  <= reg_write_n;
            mem_mem_read_o   <= mem_read_n;
            mem_mem_write_o  <= mem_write_n;
            mem_funct3_o     <= funct3_n;
            fwd_valid_o      <= fwd_valid_n;
            mul_count_o      <= mul_count_n;
        end
    end

    assign fwd_rd_addr_o = mem_rd_addr_o;
    assign fwd_data_o    = mem_result_o;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: a behavioural model pushes the expected
// register image on each drive; it is popped and compared one cycle later.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_mul, reg_write, mem_read, mem_write, stall, flush;
    logic [31:0] alu_result, mul_result, store_data;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;

    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, fwd_valid;
    logic [31:0] mem_result, mem_store_data, fwd_data, mul_count;
    logic [4:0]  mem_rd_addr, fwd_rd_addr;
    logic [2:0]  mem_funct3;

    logic        w_valid, w_reg_write, w_mem_read, w_mem_write, w_fwd_valid;
    logic [31:0] w_result, w_store_data, w_fwd_data;
    logic [4:0]  w_rd_addr, w_fwd_rd_addr;
    logic [2:0]  w_funct3;
    logic [3:0]  w_mul_count;

    int   total = 0;
    int   bad   = 0;
    obs_t m;
    obs_t sb[$];
    obs_t e, g;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_is_mul_i(ex_is_mul),
        .alu_result_i(alu_result), .mul_result_i(mul_result), .store_data_i(store_data),
        .rd_addr_i(rd_addr), .reg_write_i(reg_write), .mem_read_i(mem_read),
        .mem_write_i(mem_write), .funct3_i(funct3), .stall_i(stall), .flush_i(flush),
        .mem_valid_o(mem_valid), .mem_result_o(mem_result), .mem_store_data_o(mem_store_data),
        .mem_rd_addr_o(mem_rd_addr), .mem_reg_write_o(mem_reg_write),
        .mem_mem_read_o(mem_mem_read), .mem_mem_write_o(mem_mem_write),
        .mem_funct3_o(mem_funct3), .fwd_valid_o(fwd_valid), .fwd_rd_addr_o(fwd_rd_addr),
        .fwd_data_o(fwd_data), .mul_count_o(mul_count)
    );

    ex_mem_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_is_mul_i(ex_is_mul),
        .alu_result_i(alu_result), .mul_result_i(mul_result), .store_data_i(store_data),
        .rd_addr_i(rd_addr), .reg_write_i(reg_write), .mem_read_i(mem_read),
        .mem_write_i(mem_write), .funct3_i(funct3), .stall_i(stall), .flush_i(flush),
        .mem_valid_o(w_valid), .mem_result_o(w_result), .mem_store_data_o(w_store_data),
        .mem_rd_addr_o(w_rd_addr), .mem_reg_write_o(w_reg_write),
        .mem_mem_read_o(w_mem_read), .mem_mem_write_o(w_mem_write),
        .mem_funct3_o(w_funct3), .fwd_valid_o(w_fwd_valid), .fwd_rd_addr_o(w_fwd_rd_addr),
        .fwd_data_o(w_fwd_data), .mul_count_o(w_mul_count)
    );

    // The decoder never issues a simultaneous load and store
    always @(posedge clk) begin
        if (rst_n) assert (!(mem_read && mem_write));
    end

    function automatic obs_t sample();
        obs_t o;
        o = '{mem_valid, mem_result, mem_store_data, mem_rd_addr, mem_reg_write,
              mem_mem_read, mem_mem_write, mem_funct3, fwd_valid, fwd_rd_addr,
              fwd_data, mul_count, w_mul_count};
        return o;
    endfunction

    // Drive one EX beat, push the model's post-edge image, then advance past the edge
    task automatic step(input logic v, input logic mul, input logic [31:0] alu,
                        input logic [31:0] mulr, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic st, input logic fl);
        ex_valid = v; ex_is_mul = mul; alu_result = alu; mul_result = mulr;
        store_data = sd; rd_addr = rd; reg_write = rw; mem_read = mr;
        mem_write = mw; funct3 = f3; stall = st; flush = fl;
        if (fl) begin
            m.v = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
        end else if (!st) begin
            m.v   = v;
            m.res = (v && mul) ? mulr : alu;
            m.sd  = sd;
            m.rd  = rd;
            m.rw  = v & rw & (rd != 5'd0);
            m.mr  = v & mr;
            m.mw  = v & mw;
            m.f3  = f3;
            if (v && mul) begin
                m.cnt  = m.cnt + 32'd1;
                m.cnt4 = m.cnt4 + 4'd1;
            end
        end
        m.fv  = m.v & m.rw & ~m.mr;
        m.frd = m.rd;
        m.fd  = m.res;
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_is_mul = 0; alu_result = 0; mul_result = 0; store_data = 0;
        rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        stall = 0; flush = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        m = '0;
        sb.delete();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        g = sample();
        total++;
        if (g !== obs_t'(0)) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", g, obs_t'(0));
        end
    endtask

    task automatic test_mul_select();
        step(1, 1, 32'hDEAD_BEEF, 32'h0000_0C00, 32'h0, 5'd5, 1, 0, 0, 3'd0, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin bad++; $display("FAIL mul_select got=%h exp=%h", g, e); end
        total++;
        if ({mem_result, mem_rd_addr, fwd_valid, fwd_data, mul_count} !==
            {32'h0000_0C00, 5'd5, 1'b1, 32'h0000_0C00, 32'd1}) begin
            bad++;
            $display("FAIL mul_select_fields got res=%h rd=%0d fv=%b fd=%h cnt=%0d",
                     mem_result, mem_rd_addr, fwd_valid, fwd_data, mul_count);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 32'h1234, 32'h0, 32'h55, 5'd7, 1, 0, 0, 3'd2, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin bad++; $display("FAIL stall_load got=%h exp=%h", g, e); end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h9999, 32'h9999, 32'h66, 5'd9, 1, 0, 0, 3'd1, 1, 0);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, g, e); end
            total++;
            if ({mem_result, mem_rd_addr, mul_count} !== {32'h1234, 5'd7, 32'd1}) begin
                bad++;
                $display("FAIL stall_fields%0d got res=%h rd=%0d cnt=%0d exp res=1234 rd=7 cnt=1",
                         i, mem_result, mem_rd_addr, mul_count);
            end
        end
    endtask

    task automatic test_flush_vs_stall();
        step(1, 1, 32'h0, 32'h4444, 32'h77, 5'd4, 1, 0, 1, 3'd2, 1, 1);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin bad++; $display("FAIL flush_stall got=%h exp=%h", g, e); end
        total++;
        if ({mem_valid, mem_mem_write, mem_reg_write, fwd_valid, mul_count} !== {4'b0, 32'd1}) begin
            bad++;
            $display("FAIL flush_fields got v=%b mw=%b rw=%b fv=%b cnt=%0d exp 0 0 0 0 1",
                     mem_valid, mem_mem_write, mem_reg_write, fwd_valid, mul_count);
        end
    endtask

    task automatic test_qualification();
        step(1, 0, 32'h100, 32'h0, 32'h0, 5'd3, 1, 1, 0, 3'd2, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e || fwd_valid !== 1'b0 || mem_mem_read !== 1'b1) begin
            bad++; $display("FAIL qual_load got=%h exp=%h", g, e);
        end
        step(1, 0, 32'h200, 32'h0, 32'h0, 5'd0, 1, 0, 0, 3'd0, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e || mem_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin
            bad++; $display("FAIL qual_rd0 got=%h exp=%h", g, e);
        end
        step(0, 0, 32'h300, 32'h0, 32'hABCD, 5'd6, 0, 0, 1, 3'd2, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e || mem_mem_write !== 1'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL qual_invalid_store got=%h exp=%h", g, e);
        end
        // MUL to x0 drops the write but still counts
        step(1, 1, 32'h0, 32'h400, 32'h0, 5'd0, 1, 0, 0, 3'd0, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e) begin bad++; $display("FAIL qual_mul_x0 got=%h exp=%h", g, e); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(r[0], r[1], $urandom, $urandom, $urandom, 5'(r[6:2]), r[7], r[8],
                 ~r[8] & r[9], 3'(r[12:10]), (r[15:13] == 3'd0), (r[18:16] == 3'd0));
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 32'h0, 32'hCAFE_F00D, 32'h1, 5'd12, 1, 0, 0, 3'd5, 0, 0);
        e = sb.pop_front(); g = sample();
        total++;
        if (g !== e || mem_valid !== 1'b1) begin
            bad++; $display("FAIL async_pre got=%h exp=%h", g, e);
        end
        #2;
        rst_n = 1'b0;
        m = '0;
        sb.delete();
        #1;
        g = sample();
        total++;
        if (g !== obs_t'(0)) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", g, obs_t'(0));
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 32'h0, 32'(i), 32'h0, 5'd1, 1, 0, 0, 3'd0, 0, 0);
            e = sb.pop_front(); g = sample();
            total++;
            if (g !== e) begin bad++; $display("FAIL wrap%0d got=%h exp=%h", i, g, e); end
        end
        total++;
        if (w_mul_count !== 4'd1 || mul_count !== 32'd17) begin
            bad++;
            $display("FAIL wrap_final got cnt4=%0d cnt=%0d exp cnt4=1 cnt=17", w_mul_count, mul_count);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m = '0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_mul_select();
        test_stall();
        test_flush_vs_stall();
        test_qualification();
        test_back_to_back();
        test_async_reset();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
